// File: rtl/csr_counters_pkg.sv
// Shared constants for the csr_counters block: CSR addresses,
// csr_modify bit positions and mcountinhibit bit positions.
package csr_pkg;

  // Machine-mode read/write counter CSRs
  localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;

  // User-mode read-only shadows
  localparam logic [11:0] ADDR_CYCLE         = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH        = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET       = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH      = 12'hC82;
  localparam logic [11:0] ADDR_TIME          = 12'hC01;
  localparam logic [11:0] ADDR_TIMEH         = 12'hC81;

  // csr_modify bit positions
  localparam int MOD_WRITE = 0;
  localparam int MOD_SET   = 1;
  localparam int MOD_CLEAR = 2;

  // mcountinhibit implemented bits
  localparam int INH_CY = 0;
  localparam int INH_IR = 2;

endpackage

// File: rtl/csr_counters_counter64.sv
// csr_counter64: a WIDTH-bit counter (WIDTH in 33..64) presented as a
// zero-extended 64-bit value. Either 32-bit half can be written; a write
// to either half suppresses the increment for that cycle. Wraps silently.
module csr_counter64 #(
  parameter int WIDTH = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        inc,
  input  logic        inhibit,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wval,
  output logic [63:0] count
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [63:0]      merged;

  // Next value: half-writes take priority over the increment
  always_comb begin
    merged = 64'(cnt_q);
    if (wr_lo) merged[31:0]  = wval;
    if (wr_hi) merged[63:32] = wval;
    cnt_d = cnt_q;
    if (wr_lo || wr_hi) begin
      cnt_d = merged[WIDTH-1:0];
    end else if (inc && !inhibit) begin
      cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Counter register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count = 64'(cnt_q);

endmodule

// File: rtl/csr_counters.sv
// csr_counters: responder for the counter CSRs (mcycle, minstret,
// mcountinhibit and their read-only shadows). Optional time/timeh CSRs
// are built when CSR_COUNTERS_TIME_EN is defined.
//
// Request/response protocol: a request is present in any cycle where
// csr_read=1 or csr_modify!=0; it is sampled at the rising edge and there
// is no ready/backpressure. Exactly one cycle later csr_valid and
// csr_rdata show the result for one cycle only: csr_valid=1 means the
// access was accepted and csr_rdata holds the pre-modify value; otherwise
// both are 0 so the outputs can be OR-combined with other CSR sources.
module csr_counters
  import csr_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int TIME_DIV = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        retired,
  input  logic        csr_read,
  input  logic [2:0]  csr_modify,
  input  logic [31:0] csr_wdata,
  input  logic [11:0] csr_addr,
  output logic [31:0] csr_rdata,
  output logic        csr_valid,
  output logic [63:0] cnt_cycle
);

  logic [63:0] mcycle, minstret;
  logic        cy_q, cy_d, ir_q, ir_d;
  logic        valid_q, valid_d;
  logic [31:0] rdata_q, rdata_d;

  logic        req, mod_onehot, impl, writable, acc_ok, do_wr;
  logic [31:0] old_val, new_val;
  logic        wr_cyc_lo, wr_cyc_hi, wr_ins_lo, wr_ins_hi;

`ifdef CSR_COUNTERS_TIME_EN
  logic [63:0] mtime;
  logic [31:0] presc_q, presc_d;
  logic        tick;
`endif

  // Address decode: implemented/writable flags and the current value
  always_comb begin
    impl     = 1'b1;
    writable = 1'b0;
    old_val  = 32'd0;
    case (csr_addr)
      ADDR_MCYCLE:        begin old_val = mcycle[31:0];    writable = 1'b1; end
      ADDR_MCYCLEH:       begin old_val = mcycle[63:32];   writable = 1'b1; end
      ADDR_MINSTRET:      begin old_val = minstret[31:0];  writable = 1'b1; end
      ADDR_MINSTRETH:     begin old_val = minstret[63:32]; writable = 1'b1; end
      ADDR_MCOUNTINHIBIT: begin
        old_val[INH_CY] = cy_q;
        old_val[INH_IR] = ir_q;
        writable        = 1'b1;
      end
      ADDR_CYCLE:         old_val = mcycle[31:0];
      ADDR_CYCLEH:        old_val = mcycle[63:32];
      ADDR_INSTRET:       old_val = minstret[31:0];
      ADDR_INSTRETH:      old_val = minstret[63:32];
`ifdef CSR_COUNTERS_TIME_EN
      ADDR_TIME:          old_val = mtime[31:0];
      ADDR_TIMEH:         old_val = mtime[63:32];
`endif
      default:            impl = 1'b0;
    endcase
  end

  // Acceptance and modify result; set/clear with zero operand is
  // accepted but is not a write, so counting carries on undisturbed
  always_comb begin
    req        = csr_read || (csr_modify != 3'd0);
    mod_onehot = (csr_modify & (csr_modify - 3'd1)) == 3'd0;
    acc_ok     = req && impl && mod_onehot && ((csr_modify == 3'd0) || writable);
    new_val    = old_val;
    if (csr_modify[MOD_WRITE])      new_val = csr_wdata;
    else if (csr_modify[MOD_SET])   new_val = old_val | csr_wdata;
    else if (csr_modify[MOD_CLEAR]) new_val = old_val & ~csr_wdata;
    do_wr = acc_ok && (csr_modify[MOD_WRITE] ||
            ((csr_modify[MOD_SET] || csr_modify[MOD_CLEAR]) && (csr_wdata != 32'd0)));
    wr_cyc_lo = do_wr && (csr_addr == ADDR_MCYCLE);
    wr_cyc_hi = do_wr && (csr_addr == ADDR_MCYCLEH);
    wr_ins_lo = do_wr && (csr_addr == ADDR_MINSTRET);
    wr_ins_hi = do_wr && (csr_addr == ADDR_MINSTRETH);
    cy_d = cy_q;
    ir_d = ir_q;
    if (do_wr && (csr_addr == ADDR_MCOUNTINHIBIT)) begin
      cy_d = new_val[INH_CY];
      ir_d = new_val[INH_IR];
    end
    valid_d = acc_ok;
    rdata_d = acc_ok ? old_val : 32'd0;
  end

  // Inhibit bits and the one-cycle response register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cy_q    <= 1'b0;
      ir_q    <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      cy_q    <= cy_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
    end
  end

  csr_counter64 #(.WIDTH(WIDTH)) u_mcycle (
    .clk     (clk),
    .rstn    (rstn),
    .inc     (1'b1),
    .inhibit (cy_q),
    .wr_lo   (wr_cyc_lo),
    .wr_hi   (wr_cyc_hi),
    .wval    (new_val),
    .count   (mcycle)
  );

  csr_counter64 #(.WIDTH(WIDTH)) u_minstret (
    .clk     (clk),
    .rstn    (rstn),
    .inc     (retired),
    .inhibit (ir_q),
    .wr_lo   (wr_ins_lo),
    .wr_hi   (wr_ins_hi),
    .wval    (new_val),
    .count   (minstret)
  );

`ifdef CSR_COUNTERS_TIME_EN
  // Prescaler: tick on the last cycle of every TIME_DIV-cycle period
  always_comb begin
    tick    = (presc_q == 32'(TIME_DIV - 1));
    presc_d = tick ? 32'd0 : presc_q + 32'd1;
  end

  // Prescaler register, restarts from zero at reset
  always_ff @(posedge clk) begin
    if (!rstn) presc_q <= 32'd0;
    else       presc_q <= presc_d;
  end

  csr_counter64 #(.WIDTH(WIDTH)) u_time (
    .clk     (clk),
    .rstn    (rstn),
    .inc     (tick),
    .inhibit (1'b0),
    .wr_lo   (1'b0),
    .wr_hi   (1'b0),
    .wval    (32'd0),
    .count   (mtime)
  );
`endif

  assign csr_valid = valid_q;
  assign csr_rdata = rdata_q;
  assign cnt_cycle = mcycle;

endmodule
